music_box_input_debouncer: RTL and testbench
============================================

MUSIC_BOX_INPUT_DEBOUNCER -- requirements
Module: music_box_input_debouncer

Interface
REQ-001 Parameter CHANNELS, default 10, number of independent active-low inputs (4 function buttons + 6 music keys).
REQ-002 Parameter TICK_DIVIDE, default 50000, clock_50Mhz cycles per sample tick (1 ms).
REQ-003 Parameter STABLE_TICKS, default 20, consecutive differing ticks required to accept a new level; legal range 1..255.
REQ-004 clock_50Mhz  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 raw_buttons_n  input  CHANNELS  asynchronous GPIO levels, 0 = pressed.
REQ-007 debounced_n  output  CHANNELS  filtered levels, 0 = pressed; drives the state controller's input_*_n and input_MusicKey.
REQ-008 press_pulse  output  CHANNELS  one-cycle strobe per accepted 1->0 transition.
REQ-009 release_pulse  output  CHANNELS  one-cycle strobe per accepted 0->1 transition.
REQ-010 sample_tick  output  1  one-cycle strobe marking each sample tick, for debug.

Function
REQ-011 Each raw bit SHALL pass a 2-flop synchronizer; the synchronized value (sync_n) is the only value the filter uses.
REQ-012 The prescaler SHALL count 0..TICK_DIVIDE-1, wrap to 0, and assert sample_tick for exactly the cycle it holds TICK_DIVIDE-1.
REQ-013 Each channel SHALL run a 4-state FSM: RELEASED, PRESS_PENDING, HELD, RELEASE_PENDING.
REQ-014 RELEASED -> PRESS_PENDING when sync_n=0; HELD -> RELEASE_PENDING when sync_n=1; counter cleared on entry.
REQ-015 In a PENDING state, the channel counter SHALL increment by 1 on each sample_tick cycle where sync_n still differs from debounced_n.
REQ-016 In a PENDING state, a cycle where sync_n equals debounced_n SHALL return the FSM to its stable state and clear the counter, tick or not.
REQ-017 When the increment would make the counter equal STABLE_TICKS, the FSM SHALL move to HELD (from PRESS_PENDING) or RELEASED (from RELEASE_PENDING) and clear the counter.
REQ-018 debounced_n SHALL be 1 in RELEASED/PRESS_PENDING and 0 in HELD/RELEASE_PENDING, updated on the same edge as the state.
REQ-019 press_pulse/release_pulse SHALL be registered and high only during the first cycle debounced_n shows the new level.
REQ-020 Counter width SHALL be 8 bits; it SHALL never exceed STABLE_TICKS-1 and never wrap.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL each produce their own pulse in the same cycle.
REQ-022 Latency raw edge -> debounced_n SHALL be 2 sync cycles plus STABLE_TICKS ticks, i.e. between (STABLE_TICKS-1)*TICK_DIVIDE+3 and STABLE_TICKS*TICK_DIVIDE+2 cycles.
REQ-023 With STABLE_TICKS=1, the first tick after the change SHALL accept the new level.

Reset
REQ-024 Asserting reset_n low SHALL immediately force: synchronizer flops 1, prescaler 0, all FSMs RELEASED, counters 0, debounced_n all 1, press_pulse/release_pulse/sample_tick 0.
REQ-025 Reset mid-PENDING SHALL discard partial counts; no pulse SHALL be generated by reset assertion or release.
REQ-026 After release, a button held low through reset SHALL be accepted as a fresh press with full REQ-022 latency.

Structure
REQ-027 Package music_box_pkg SHALL hold the default CHANNELS, TICK_DIVIDE, STABLE_TICKS constants, channel index constants (PLAY_SONG0=0, PLAY_SONG1=1, MAKE_RECORDING=2, PLAY_RECORDING=3, MUSIC_KEY_BASE=4), and the channel state enum.
REQ-028 Per-channel synchronizer+FSM+counter SHALL be sub-module debounce_channel, instantiated CHANNELS times by generate; prescaler stays in the top.

Verification (TICK_DIVIDE=4, STABLE_TICKS=3 unless noted)
REQ-029 Hold raw_buttons_n[0]=0 -> debounced_n[0] falls 11..14 cycles later, press_pulse[0] high exactly 1 cycle, other outputs unchanged.
REQ-030 Low glitch of 6 cycles on bit 1 -> debounced_n[1] stays 1, no pulses, counter back to 0.
REQ-031 Bits 2 and 5 pressed in the same cycle -> both fall in the same cycle with two simultaneous press_pulse bits; release both -> two release_pulse bits.
REQ-032 Reset asserted after 2 ticks pending on bit 3 -> all outputs at reset values immediately; after reset release, full latency re-applies.
REQ-033 STABLE_TICKS=1: press -> acceptance on the first sample_tick after sync; release symmetric.
REQ-034 Defaults (50000, 20): single press -> debounced_n falls between 950003 and 1000002 cycles later.

Source files
------------

// File: rtl/music_box_pkg.sv
// Shared constants and channel state encoding for the music box input debouncer.
// Channel indices map the GPIO bit order onto the state controller inputs.
package music_box_pkg;

  localparam int CHANNELS_DEF     = 10;
  localparam int TICK_DIVIDE_DEF  = 50000;
  localparam int STABLE_TICKS_DEF = 20;

  localparam int PLAY_SONG0     = 0;
  localparam int PLAY_SONG1     = 1;
  localparam int MAKE_RECORDING = 2;
  localparam int PLAY_RECORDING = 3;
  localparam int MUSIC_KEY_BASE = 4;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    CH_RELEASED        = 2'd0,
    CH_PRESS_PENDING   = 2'd1,
    CH_HELD            = 2'd2,
    CH_RELEASE_PENDING = 2'd3
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, 4-state accept FSM and tick counter.
// A new level is accepted only after STABLE_TICKS consecutive differing sample ticks.
module debounce_channel
  import music_box_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  input  logic tick,
  output logic debounced_n,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] ST_C = CNT_W'(STABLE_TICKS);

  logic [1:0]       sync_q, sync_d;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             sync_n;

  assign sync_d  = {sync_q[0], raw_n};
  assign sync_n  = sync_q[1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      CH_RELEASED: begin
        if (!sync_n) begin
          state_d = CH_PRESS_PENDING;
          cnt_d   = '0;
        end
      end
      CH_PRESS_PENDING: begin
        // a bounce back to the accepted level discards the partial count
        if (sync_n) begin
          state_d = CH_RELEASED;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == ST_C) begin
            state_d = CH_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      CH_HELD: begin
        if (sync_n) begin
          state_d = CH_RELEASE_PENDING;
          cnt_d   = '0;
        end
      end
      CH_RELEASE_PENDING: begin
        if (!sync_n) begin
          state_d = CH_HELD;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == ST_C) begin
            state_d   = CH_RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = CH_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= CH_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Filtered level follows the state register directly, so it flips on the accept edge.
  assign debounced_n   = !((state_q == CH_HELD) || (state_q == CH_RELEASE_PENDING));
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/music_box_input_debouncer.sv
// Debouncer for the music box buttons and keys: shared sample-tick prescaler
// plus one independent debounce_channel per active-low input.
module music_box_input_debouncer
  import music_box_pkg::*;
#(
  parameter int CHANNELS     = CHANNELS_DEF,
  parameter int TICK_DIVIDE  = TICK_DIVIDE_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic                clock_50Mhz,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw_buttons_n,
  output logic [CHANNELS-1:0] debounced_n,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                sample_tick
);

  localparam int PW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDE - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign sample_tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (presc_q == PRESC_LAST) presc_d = '0;
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk          (clock_50Mhz),
      .rst_n        (reset_n),
      .raw_n        (raw_buttons_n[i]),
      .tick         (sample_tick),
      .debounced_n  (debounced_n[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_music_box_input_debouncer.sv
// Directed bench: table of hold-and-observe vectors plus hand sequences for
// latency windows, pulse width, reset mid-pending and the single-tick variant.
module tb_music_box_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic [9:0] raw1, db1, pr1, rel1;
  logic [9:0] raw2, db2, pr2, rel2;
  logic       tick1, tick2;

  int total = 0;
  int pass  = 0;

  music_box_input_debouncer #(
    .CHANNELS(10), .TICK_DIVIDE(4), .STABLE_TICKS(3)
  ) u_dut (
    .clock_50Mhz  (clk),
    .reset_n      (rst_n),
    .raw_buttons_n(raw1),
    .debounced_n  (db1),
    .press_pulse  (pr1),
    .release_pulse(rel1),
    .sample_tick  (tick1)
  );

  music_box_input_debouncer #(
    .CHANNELS(10), .TICK_DIVIDE(4), .STABLE_TICKS(1)
  ) u_st1 (
    .clock_50Mhz  (clk),
    .reset_n      (rst_n),
    .raw_buttons_n(raw2),
    .debounced_n  (db2),
    .press_pulse  (pr2),
    .release_pulse(rel2),
    .sample_tick  (tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] raw;
    int         hold;
    logic [9:0] exp_db;
    logic [9:0] exp_press;
    logic [9:0] exp_rel;
    int         exp_pcyc;
  } vec_t;

  vec_t vt[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int val, input int lo, input int hi);
    total++;
    if (val >= lo && val <= hi) pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, val, lo, hi);
  endtask

  // Caller changes raw just after an edge; the next edge is the capture edge (k=1),
  // and latency is reported relative to that capture edge.
  task automatic accept_check(input string nm, input bit st1, input int ch, input logic lvl,
                              input int lo, input int hi);
    logic [9:0] d, p;
    int lat;
    lat = 999;
    p = '0;
    for (int k = 1; k <= 60; k++) begin
      step();
      d = st1 ? db2 : db1;
      if (d[ch] == lvl) begin
        lat = k - 1;
        break;
      end
    end
    chk_rng({nm, "_latency"}, lat, lo, hi);
    p = st1 ? (lvl ? rel2 : pr2) : (lvl ? rel1 : pr1);
    chk({nm, "_pulse_on"}, 32'(p), 32'(10'(1) << ch));
    step();
    p = st1 ? (lvl ? rel2 : pr2) : (lvl ? rel1 : pr1);
    chk({nm, "_pulse_off"}, 32'(p), 32'h0);
    d = st1 ? db2 : db1;
    chk({nm, "_level_kept"}, 32'(d[ch]), 32'(lvl));
  endtask

  initial begin
    logic [9:0] por, ror;
    int pc, n;
    logic exp_tick[8];

    vt[0] = '{10'h3FE, 20, 10'h3FE, 10'h001, 10'h000, 1};
    vt[1] = '{10'h3FF, 20, 10'h3FF, 10'h000, 10'h001, 1};
    vt[2] = '{10'h3FD,  6, 10'h3FF, 10'h000, 10'h000, 0};
    vt[3] = '{10'h3FF, 20, 10'h3FF, 10'h000, 10'h000, 0};
    vt[4] = '{10'h3DB, 20, 10'h3DB, 10'h024, 10'h000, 1};
    vt[5] = '{10'h3FF, 20, 10'h3FF, 10'h000, 10'h024, 1};
    vt[6] = '{10'h000, 20, 10'h000, 10'h3FF, 10'h000, 1};
    vt[7] = '{10'h3FF, 20, 10'h3FF, 10'h000, 10'h3FF, 1};
    exp_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    raw1  = 10'h3FF;
    raw2  = 10'h3FF;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_db",     32'(db1),   32'h3FF);
    chk("rst_press",  32'(pr1),   32'h0);
    chk("rst_rel",    32'(rel1),  32'h0);
    chk("rst_tick",   32'(tick1), 32'h0);
    chk("rst_db_st1", 32'(db2),   32'h3FF);
    chk("rst_tick_st1", 32'(tick2), 32'h0);
    rst_n = 1'b1;

    // Prescaler starts at 0 after reset: tick on the cycle holding 3, every 4 cycles.
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("tick_phase%0d", i), 32'(tick1), 32'(exp_tick[i]));
    end

    for (int v = 0; v < 8; v++) begin
      raw1 = vt[v].raw;
      por = '0;
      ror = '0;
      pc = 0;
      for (int c = 0; c < vt[v].hold; c++) begin
        step();
        por |= pr1;
        ror |= rel1;
        if ((|pr1) || (|rel1)) pc++;
      end
      chk($sformatf("vec%0d_db", v),    32'(db1), 32'(vt[v].exp_db));
      chk($sformatf("vec%0d_press", v), 32'(por), 32'(vt[v].exp_press));
      chk($sformatf("vec%0d_rel", v),   32'(ror), 32'(vt[v].exp_rel));
      chk($sformatf("vec%0d_pcyc", v),  32'(pc),  32'(vt[v].exp_pcyc));
    end

    // Single press/release on bit 0: latency window and one-cycle strobes.
    raw1[0] = 1'b0;
    accept_check("b0_press", 1'b0, 0, 1'b0, 11, 14);
    chk("b0_others", 32'(db1), 32'h3FE);
    raw1[0] = 1'b1;
    accept_check("b0_release", 1'b0, 0, 1'b1, 11, 14);

    // Reset after two counted ticks on bit 3 must discard the count.
    raw1[3] = 1'b0;
    step(); step(); step();
    n = 0;
    for (int g = 0; g < 20 && n < 2; g++) begin
      if (tick1) n++;
      step();
    end
    chk("b3_still_pending", 32'(db1), 32'h3FF);
    rst_n = 1'b0;
    #1;
    chk("b3_rst_db",    32'(db1),   32'h3FF);
    chk("b3_rst_press", 32'(pr1),   32'h0);
    chk("b3_rst_rel",   32'(rel1),  32'h0);
    chk("b3_rst_tick",  32'(tick1), 32'h0);
    pc = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if ((|pr1) || (|rel1)) pc++;
    end
    chk("b3_rst_no_pulse", 32'(pc), 32'h0);
    rst_n = 1'b1;
    accept_check("b3_after_rst", 1'b0, 3, 1'b0, 11, 14);
    raw1[3] = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("b3_released", 32'(db1), 32'h3FF);

    // Single-tick variant accepts on the first tick after the FSM sees the change.
    raw2[7] = 1'b0;
    accept_check("st1_press", 1'b1, 7, 1'b0, 3, 6);
    raw2[7] = 1'b1;
    accept_check("st1_release", 1'b1, 7, 1'b1, 3, 6);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
